jt12_keyon_ctrl: RTL and testbench

- Per-operator key-on state keeper for the JT12 (YM2612) register block.
- Holds one key-on bit for each of the 24 operator slots (6 channels × 4 operators).
- Updates those bits from key-on register writes as the slot sequencer passes each slot.
- Supports CSM timer-A forced key-on for channel 3, and delivers the key-on of the current slot to the envelope generator one enabled cycle later (stage II).

---
 rtl/jt12_keyon_ctrl_pkg.sv | 44 ++++
 rtl/jt12_keyon_ctrl_if.sv | 36 +++
 rtl/jt12_keyon_store.sv | 31 +++
 rtl/jt12_keyon_ctrl.sv | 55 +++++
 tb/tb_jt12_keyon_ctrl.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/jt12_keyon_ctrl_pkg.sv
// Shared constants and slot helpers for the JT12 per-operator key-on keeper.
// Slot operator codes follow the sequencer order S1, S3, S2, S4.
package jt12_keyon_ctrl_pkg;

  typedef enum logic [1:0] {
    SLOT_S1 = 2'd0,
    SLOT_S3 = 2'd1,
    SLOT_S2 = 2'd2,
    SLOT_S4 = 2'd3
  } slot_op_e;

  localparam logic [2:0] CH3 = 3'd2;
  localparam logic [2:0] CH6 = 3'd6;

  localparam int SLOT_COUNT = 24;
  localparam int SLOT_AW    = 5;
  localparam logic [SLOT_AW-1:0] SLOT_MAX = SLOT_AW'(SLOT_COUNT - 1);

  // Channel codes 3 and 7 are holes in the YM2612 channel map.
  function automatic logic ch_valid(input logic [2:0] ch);
    return (ch != 3'd3) && (ch <= CH6);
  endfunction

  // Dense slot number 0..23; codes 4..6 fold down onto 3..5.
  function automatic logic [SLOT_AW-1:0] slot_index(input logic [1:0] op,
                                                    input logic [2:0] ch);
    logic [2:0] ch_lin;
    ch_lin = ch[2] ? (ch - 3'd1) : ch;
    return (SLOT_AW'(op) * SLOT_AW'(6)) + SLOT_AW'(ch_lin);
  endfunction

  // Write data carries OP1..OP4 in bit order, but slots arrive as S1,S3,S2,S4.
  function automatic logic op_sel(input logic [1:0] op, input logic [3:0] keyon_op);
    logic bit_out;
    case (slot_op_e'(op))
      SLOT_S1: bit_out = keyon_op[0];
      SLOT_S3: bit_out = keyon_op[2];
      SLOT_S2: bit_out = keyon_op[1];
      default: bit_out = keyon_op[3];
    endcase
    return bit_out;
  endfunction

endpackage

// File: rtl/jt12_keyon_ctrl_if.sv
// Register-block side signals of the key-on keeper: write request, slot
// sequencer position, CSM controls and the stage-II key-on result.
interface jt12_keyon_ctrl_if;

  logic [3:0] keyon_op;
  logic [2:0] keyon_ch;
  logic [1:0] cur_op;
  logic [2:0] cur_ch;
  logic       up_keyon;
  logic       csm;
  logic       overflow_A;
  logic       keyon_II;

  modport master (
    output keyon_op,
    output keyon_ch,
    output cur_op,
    output cur_ch,
    output up_keyon,
    output csm,
    output overflow_A,
    input  keyon_II
  );

  modport slave (
    input  keyon_op,
    input  keyon_ch,
    input  cur_op,
    input  cur_ch,
    input  up_keyon,
    input  csm,
    input  overflow_A,
    output keyon_II
  );

endinterface

// File: rtl/jt12_keyon_store.sv
// 24x1 key-on bit store: one combinational read port, one write port,
// both addressed by dense slot number; asynchronous clear.
module jt12_keyon_store
  import jt12_keyon_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_we,
  input  logic [SLOT_AW-1:0] i_waddr,
  input  logic               i_wdata,
  input  logic [SLOT_AW-1:0] i_raddr,
  output logic               o_rdata
);

  logic [SLOT_COUNT-1:0] r_bits;

  // NOTE: this store is only 24 flops, so clearing it on reset is cheap and
  // gives a defined all-keys-off state; larger RAM-style arrays would not.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bits <= '0;
    end else if (i_we && (i_waddr <= SLOT_MAX)) begin
      r_bits[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = (i_raddr <= SLOT_MAX) ? r_bits[i_raddr] : 1'b0;

endmodule

// File: rtl/jt12_keyon_ctrl.sv
// Per-operator key-on keeper: applies key-on writes as slots pass, adds the
// CSM timer-A force for channel 3 and registers the result as keyon_II.
module jt12_keyon_ctrl
  import jt12_keyon_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  jt12_keyon_ctrl_if.slave  bus
);

  logic               w_ch_valid;
  logic [SLOT_AW-1:0] w_slot;
  logic               w_sel_bit;
  logic               w_wr_hit;
  logic               w_we;
  logic               w_rd_bit;
  logic               w_new_bit;
  logic               w_csm_hit;
  logic               r_keyon_II;

  // NOTE: every always_comb output is assigned on every path, so no latch
  // can be inferred.
  always_comb begin
    w_ch_valid = ch_valid(bus.cur_ch);
    w_slot     = slot_index(bus.cur_op, bus.cur_ch);
    w_sel_bit  = op_sel(bus.cur_op, bus.keyon_op);
    w_wr_hit   = bus.up_keyon && (bus.keyon_ch == bus.cur_ch) && w_ch_valid;
    w_we       = clk_en && w_wr_hit;
    // Write-through: a slot being written shows its new value on this edge.
    w_new_bit  = w_wr_hit ? w_sel_bit : (w_rd_bit && w_ch_valid);
    w_csm_hit  = bus.csm && bus.overflow_A && (bus.cur_ch == CH3);
  end

  jt12_keyon_store u_store (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_we),
    .i_waddr (w_slot),
    .i_wdata (w_sel_bit),
    .i_raddr (w_slot),
    .o_rdata (w_rd_bit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_keyon_II <= 1'b0;
    end else if (clk_en) begin
      r_keyon_II <= w_new_bit || w_csm_hit;
    end
  end

  assign bus.keyon_II = r_keyon_II;

endmodule

// File: tb/tb_jt12_keyon_ctrl.sv
// Bench for jt12_keyon_ctrl: directed slot rotations checked every cycle
// against a per-channel/per-operator key table, plus literal spot checks.
module tb_jt12_keyon_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clk_en = 1'b0;
  bit   started = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  jt12_keyon_ctrl_if bus ();

  jt12_keyon_ctrl dut (
    .clk    (clk),
    .rst    (rst),
    .clk_en (clk_en),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  logic [2:0] ch_codes [6] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6};

  // Model: key state per channel code and operator number (0=OP1 .. 3=OP4).
  bit keyed [8][4];
  bit exp_keyon = 1'b0;

  function automatic int op_num(input logic [1:0] slot_op);
    case (slot_op)
      2'd0: return 0;
      2'd1: return 2;
      2'd2: return 1;
      default: return 3;
    endcase
  endfunction

  function automatic bit model_writes();
    return bus.up_keyon && (bus.keyon_ch == bus.cur_ch) &&
           (bus.cur_ch != 3'd3) && (bus.cur_ch != 3'd7);
  endfunction

  function automatic bit model_out();
    bit key;
    int n;
    n = op_num(bus.cur_op);
    key = model_writes() ? bus.keyon_op[n] : keyed[bus.cur_ch][n];
    return key || (bus.csm && bus.overflow_A && (bus.cur_ch == 3'd2));
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      keyed     <= '{default: '0};
      exp_keyon <= 1'b0;
    end else if (clk_en) begin
      if (model_writes())
        keyed[bus.cur_ch][op_num(bus.cur_op)] <= bus.keyon_op[op_num(bus.cur_op)];
      exp_keyon <= model_out();
    end
  end

  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: keyon_II=%b expected=%b at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started && !rst) check("cycle", bus.keyon_II, exp_keyon);
  end

  task automatic slot(input logic [1:0] op, input logic [2:0] ch);
    @(negedge clk);
    bus.cur_op = op;
    bus.cur_ch = ch;
    clk_en     = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Disabled cycle parked on a channel-3 slot: nothing may move.
  task automatic gap();
    @(negedge clk);
    clk_en     = 1'b0;
    bus.cur_op = 2'd3;
    bus.cur_ch = 3'd2;
    @(posedge clk);
    #1;
  endtask

  task automatic rotation(input int gap_every);
    int n;
    n = 0;
    for (int op = 0; op < 4; op++) begin
      for (int c = 0; c < 6; c++) begin
        slot(2'(op), ch_codes[c]);
        n++;
        if (gap_every > 0 && (n % gap_every) == 0) gap();
      end
    end
  endtask

  task automatic write_rotation(input logic [2:0] ch, input logic [3:0] ops);
    bus.up_keyon = 1'b1;
    bus.keyon_ch = ch;
    bus.keyon_op = ops;
    rotation(7);
    bus.up_keyon = 1'b0;
    bus.keyon_op = 4'h0;
  endtask

  task automatic probe(input string name, input logic [1:0] op,
                       input logic [2:0] ch, input logic exp);
    slot(op, ch);
    check(name, bus.keyon_II, exp);
  endtask

  initial begin
    #100000;
    n_errors++;
    $display("FAIL timeout: bench did not finish");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    bus.keyon_op   = 4'h0;
    bus.keyon_ch   = 3'd0;
    bus.cur_op     = 2'd0;
    bus.cur_ch     = 3'd0;
    bus.up_keyon   = 1'b0;
    bus.csm        = 1'b0;
    bus.overflow_A = 1'b0;
    #22;
    rst = 1'b0;
    #1;
    check("reset", bus.keyon_II, 1'b0);
    started = 1'b1;

    // 1: idle rotations
    rotation(0);
    rotation(5);

    // 2: key on all of channel code 4
    write_rotation(3'd4, 4'b1111);
    rotation(5);
    probe("ch4_s1_on", 2'd0, 3'd4, 1'b1);
    probe("ch4_s4_on", 2'd3, 3'd4, 1'b1);
    probe("ch5_s1_off", 2'd0, 3'd5, 1'b0);

    // 3: OP1+OP3 on channel code 1
    write_rotation(3'd1, 4'b0101);
    rotation(0);
    probe("ch1_s1", 2'd0, 3'd1, 1'b1);
    probe("ch1_s3", 2'd1, 3'd1, 1'b1);
    probe("ch1_s2", 2'd2, 3'd1, 1'b0);
    probe("ch1_s4", 2'd3, 3'd1, 1'b0);

    // 4: key off channel code 4
    write_rotation(3'd4, 4'b0000);
    rotation(0);
    probe("ch4_s2_off", 2'd2, 3'd4, 1'b0);

    // 5: CSM force with no stored keys, then with csm low
    write_rotation(3'd1, 4'b0000);
    bus.csm = 1'b1;
    bus.overflow_A = 1'b1;
    rotation(4);
    probe("csm_ch3", 2'd2, 3'd2, 1'b1);
    probe("csm_ch2", 2'd2, 3'd1, 1'b0);
    bus.csm = 1'b0;
    rotation(4);
    probe("nocsm_ch3", 2'd2, 3'd2, 1'b0);

    // Write of zero together with a CSM hit: output forced, stored bit is 0
    bus.csm = 1'b1;
    bus.up_keyon = 1'b1;
    bus.keyon_ch = 3'd2;
    bus.keyon_op = 4'b0000;
    probe("csm_wr", 2'd1, 3'd2, 1'b1);
    bus.up_keyon = 1'b0;
    bus.csm = 1'b0;
    bus.overflow_A = 1'b0;
    probe("csm_wr_stored", 2'd1, 3'd2, 1'b0);

    // 6: channel code 3 does not exist
    write_rotation(3'd3, 4'hF);
    rotation(0);
    probe("ch_hole", 2'd0, 3'd4, 1'b0);

    // Keys set, then asynchronous reset mid-rotation with a write pending
    write_rotation(3'd5, 4'hF);
    probe("ch5_on", 2'd0, 3'd5, 1'b1);
    bus.up_keyon = 1'b1;
    bus.keyon_ch = 3'd6;
    bus.keyon_op = 4'hF;
    #3;
    rst = 1'b1;
    #1;
    check("async_rst", bus.keyon_II, 1'b0);
    bus.up_keyon = 1'b0;
    bus.keyon_op = 4'h0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    rotation(0);
    probe("post_rst_ch5", 2'd0, 3'd5, 1'b0);
    probe("post_rst_ch6", 2'd3, 3'd6, 1'b0);

    started = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
